// File: rtl/multi_crop_splice_pkg.sv
// ============================================================================
// Module      : multi_crop_splice_pkg
// Description : Shared types and helpers for the N-channel crop-and-splice stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_crop_splice_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  // Width of a counter or address covering v values; never narrower than 1 bit.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int DEF_NCH = 2;
  localparam int DEF_CW  = 640;
  localparam int OUT_W   = DEF_NCH * DEF_CW;

endpackage

`default_nettype wire

// File: rtl/splice_line_bank.sv
// ============================================================================
// Module      : splice_line_bank
// Description : One channel's ping-pong line store; simple dual-port RAM with
//               {bank,addr} on both ports and a 1-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module splice_line_bank
  import multi_crop_splice_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**(AW+1))-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/multi_crop_splice.sv
// ============================================================================
// Module      : multi_crop_splice
// Description : Cuts NCH windows from a camera line and emits them side by side
//               as a dense burst. Optional divider pixels: SPLICE_BORDER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_crop_splice
  import multi_crop_splice_pkg::*;
#(
  parameter int          IW           = 1280,
  parameter int          IH           = 960,
  parameter int          DW           = 16,
  parameter int          NCH          = 2,
  parameter int          CW           = 640,
  parameter int          CH           = 480,
  parameter int          XW           = $clog2(IW),
  parameter logic [DW-1:0] BORDER_COLOR = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cam_vs,
  input  logic                  cam_de,
  input  logic                  data_en_i,
  input  logic [DW-1:0]         cam_data,
  input  logic [NCH*XW-1:0]     hoff,
  input  logic [$clog2(IH)-1:0] voff,
  output logic                  pro_vs,
  output logic                  pro_de,
  output logic                  data_en_o,
  output logic [DW-1:0]         pro_data,
  output logic                  overrun
);

  localparam int             c_YW   = $clog2(IH);
  localparam int             c_YCW  = c_YW + 2;
  localparam int             c_AW   = clog2w(CW);
  localparam int             c_CHW  = clog2w(NCH);
  localparam logic [XW-1:0]  c_HMAX = XW'(IW - CW);
  localparam logic [XW:0]    c_CWX  = (XW+1)'(CW);
  localparam logic [c_AW-1:0]  c_ALAST  = c_AW'(CW - 1);
  localparam logic [c_CHW-1:0] c_CHLAST = c_CHW'(NCH - 1);
  localparam logic [c_YCW-1:0] c_CHY    = c_YCW'(CH);

  state_t             r_state, w_state_nxt;
  logic               r_pro_vs, r_de_d;
  logic [XW:0]        r_x;
  logic [c_YCW-1:0]   r_y;
  logic [XW-1:0]      r_hoff [NCH];
  logic [c_YW-1:0]    r_voff;
  logic               r_wb, r_rb, r_overrun;
  logic [c_AW-1:0]    r_rd_addr;
  logic [c_CHW-1:0]   r_rd_ch, r_out_ch;
  logic               r_oval;
  logic [DW-1:0]      w_rdata [NCH];
  logic [DW-1:0]      w_pix;

  logic w_vs_rise, w_de_fall, w_acc, w_qual, w_line_end, w_last_rd;

  assign w_vs_rise  = cam_vs & ~r_pro_vs;
  assign w_de_fall  = r_de_d & ~cam_de;
  assign w_acc      = cam_de & data_en_i;
  assign w_qual     = (r_y >= c_YCW'(r_voff)) && (r_y < (c_YCW'(r_voff) + c_CHY));
  assign w_line_end = w_de_fall & w_qual;
  assign w_last_rd  = (r_rd_ch == c_CHLAST) && (r_rd_addr == c_ALAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pro_vs  <= 1'b0;
      r_de_d    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_voff    <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_hoff[k] <= '0;
      end
    end else begin
      r_pro_vs <= cam_vs;
      r_de_d   <= cam_de;
      if (!cam_de) begin
        r_x <= '0;
      end else if (w_acc) begin
        r_x <= r_x + 1'b1;
      end
      if (w_vs_rise) begin
        r_y    <= '0;
        r_voff <= voff;
        for (int k = 0; k < NCH; k++) begin
          r_hoff[k] <= (hoff[k*XW +: XW] > c_HMAX) ? c_HMAX : hoff[k*XW +: XW];
        end
      end else if (w_de_fall && (r_y != '1)) begin
        r_y <= r_y + 1'b1;
      end
      // A line that ends mid-readout keeps wb, so the next line reuses its bank.
      if (w_line_end && (r_state == ST_IDLE)) begin
        r_rb <= r_wb;
        r_wb <= ~r_wb;
      end
      if (w_line_end && (r_state == ST_READ)) begin
        r_overrun <= 1'b1;
      end else if (w_vs_rise) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_line_end) w_state_nxt = ST_READ;
      ST_READ: if (w_last_rd)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_rd_ch   <= '0;
    end else if (r_state == ST_READ) begin
      if (r_rd_addr == c_ALAST) begin
        r_rd_addr <= '0;
        r_rd_ch   <= (r_rd_ch == c_CHLAST) ? '0 : r_rd_ch + 1'b1;
      end else begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
    end
  end

  // Valid and channel select track the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oval   <= 1'b0;
      r_out_ch <= '0;
    end else begin
      r_oval   <= (r_state == ST_READ);
      r_out_ch <= r_rd_ch;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [XW:0] w_rel;
    logic        w_we;

    assign w_rel = r_x - {1'b0, r_hoff[k]};
    assign w_we  = w_acc & w_qual & (r_x >= {1'b0, r_hoff[k]}) & (w_rel < c_CWX);

    splice_line_bank #(
      .DW (DW),
      .AW (c_AW)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr ({r_wb, w_rel[c_AW-1:0]}),
      .i_wdata (cam_data),
      .i_raddr ({r_rb, r_rd_addr}),
      .o_rdata (w_rdata[k])
    );
  end

`ifdef SPLICE_BORDER_EN
  logic r_out_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_first <= 1'b0;
    end else begin
      r_out_first <= (r_rd_addr == '0);
    end
  end

  always_comb begin
    w_pix = w_rdata[r_out_ch];
    if ((r_out_ch != '0) && r_out_first) begin
      w_pix = BORDER_COLOR;
    end
  end
`else
  logic w_unused_border;
  assign w_unused_border = ^BORDER_COLOR;

  always_comb begin
    w_pix = w_rdata[r_out_ch];
  end
`endif

  assign pro_vs    = r_pro_vs;
  assign pro_de    = r_oval;
  assign data_en_o = r_oval;
  assign pro_data  = r_oval ? w_pix : '0;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_multi_crop_splice.sv
// ============================================================================
// Module      : tb_multi_crop_splice
// Description : Scoreboard bench for multi_crop_splice (IW=16, CW=4, NCH=2, CH=2).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_crop_splice;

  localparam int IW = 16, IH = 8, DW = 16, NCH = 2, CW = 4, CH = 2, XW = 4;
  localparam int NOUT = NCH * CW;
  localparam logic [DW-1:0] BORDER = 16'hFFFF;

  logic clk = 1'b0;
  logic rst, cam_vs, cam_de, data_en_i;
  logic [DW-1:0] cam_data;
  logic [NCH*XW-1:0] hoff;
  logic [2:0] voff;
  logic pro_vs, pro_de, data_en_o, overrun;
  logic [DW-1:0] pro_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int blen = 0;
  logic [DW-1:0] exp_q[$];
  int start_q[$];

  int T_BASIC [NOUT] = '{0, 1, 2, 3, 6, 7, 8, 9};
  int T_CLAMP [NOUT] = '{2, 3, 4, 5, 12, 13, 14, 15};
  int T_OVR   [NOUT] = '{0, 1, 2, 3, 3, 4, 5, 6};

  multi_crop_splice #(
    .IW(IW), .IH(IH), .DW(DW), .NCH(NCH), .CW(CW), .CH(CH), .XW(XW),
    .BORDER_COLOR(BORDER)
  ) dut (
    .clk(clk), .rst(rst), .cam_vs(cam_vs), .cam_de(cam_de),
    .data_en_i(data_en_i), .cam_data(cam_data), .hoff(hoff), .voff(voff),
    .pro_vs(pro_vs), .pro_de(pro_de), .data_en_o(data_en_o),
    .pro_data(pro_data), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output pixel.
  always @(negedge clk) begin
    if (rst) begin
      blen = 0;
    end else if (pro_de) begin
      if (blen == 0) begin
        if (start_q.size() == 0) report_fail("burst_start unexpected burst");
        else check("burst_start", cyc, start_q.pop_front());
      end
      blen++;
      check("data_en_o", data_en_o, pro_de);
      if (exp_q.size() == 0) report_fail("pixel unexpected output");
      else check("pixel", pro_data, exp_q.pop_front());
    end else begin
      if (blen != 0) check("burst_len", blen, NOUT);
      blen = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_burst(input int base, input int tbl [NOUT]);
    logic [DW-1:0] v;
    for (int i = 0; i < NOUT; i++) begin
      v = 16'(base + tbl[i]);
`ifdef SPLICE_BORDER_EN
      if ((i % CW == 0) && (i != 0)) v = BORDER;
`endif
      exp_q.push_back(v);
    end
  endtask

  task automatic frame_start();
    check("pro_vs_low", pro_vs, 1'b0);
    cam_vs = 1'b1;
    tick();
    @(negedge clk);
    check("pro_vs_high", pro_vs, 1'b1);
    check("overrun_clear", overrun, 1'b0);
    @(posedge clk);
    #1;
    cam_vs = 1'b0;
    idle(3);
  endtask

  task automatic send_line(input int base, input bit sparse, input int npix,
                           input int tail, input bit expb);
    int ncyc;
    ncyc = sparse ? 2 * npix : npix;
    cam_de = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      data_en_i = sparse ? (i % 2 == 0) : 1'b1;
      cam_data  = 16'(base + (sparse ? i / 2 : i));
      tick();
    end
    cam_de    = 1'b0;
    data_en_i = 1'b0;
    cam_data  = '0;
    if (expb) start_q.push_back(cyc + 2);
    idle(tail);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pro_de) && n < 100) begin
      tick();
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0 || start_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d pixels and %0d bursts still pending", name, exp_q.size(), start_q.size());
      exp_q.delete();
      start_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cam_vs = 1'b0; cam_de = 1'b0; data_en_i = 1'b0;
    cam_data = '0; hoff = '0; voff = '0;
    idle(3);
    @(negedge clk);
    check("reset_pro_vs", pro_vs, 1'b0);
    check("reset_pro_de", pro_de, 1'b0);
    check("reset_data_en_o", data_en_o, 1'b0);
    check("reset_pro_data", pro_data, 16'h0);
    check("reset_overrun", overrun, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Basic splice: two qualified lines, third line outside the window.
    hoff = {4'd6, 4'd0}; voff = 3'd0;
    frame_start();
    for (int l = 0; l < 3; l++) begin
      if (l < 2) push_burst(256 * (l + 1), T_BASIC);
      send_line(256 * (l + 1), 1'b0, 16, 14, l < 2);
    end
    drain("basic");

    // Overlap and clamp: channel 1 offset 14 clamps to 12.
    hoff = {4'd14, 4'd2};
    frame_start();
    push_burst(16'h400, T_CLAMP);
    send_line(16'h400, 1'b0, 16, 14, 1'b1);
    drain("clamp");

    // Vertical window; mid-frame offset changes must not take effect.
    hoff = {4'd6, 4'd0}; voff = 3'd3;
    frame_start();
    for (int l = 0; l < 6; l++) begin
      if (l == 2) begin
        hoff = {4'd14, 4'd2};
        voff = 3'd0;
      end
      if (l == 3 || l == 4) push_burst(16'h1000 * l, T_BASIC);
      send_line(16'h1000 * l, 1'b0, 16, 14, (l == 3 || l == 4));
    end
    drain("vertical");

    // data_en_i gating: pixels every other clock.
    hoff = {4'd6, 4'd0}; voff = 3'd0;
    frame_start();
    push_burst(16'h700, T_BASIC);
    send_line(16'h700, 1'b1, 16, 14, 1'b1);
    drain("gating");

    // Overrun: second qualified line ends while the first is still read out.
    hoff = {4'd3, 4'd0};
    frame_start();
    push_burst(16'h800, T_OVR);
    send_line(16'h800, 1'b0, 7, 1, 1'b1);
    send_line(16'h900, 1'b0, 7, 20, 1'b0);
    drain("overrun_burst");
    check("overrun_set", overrun, 1'b1);
    send_line(16'hA00, 1'b0, 16, 14, 1'b0);
    check("overrun_sticky", overrun, 1'b1);
    frame_start();
    push_burst(16'hB00, T_OVR);
    send_line(16'hB00, 1'b0, 16, 14, 1'b1);
    drain("after_overrun");

    // Reset in the middle of a burst.
    hoff = {4'd6, 4'd0};
    frame_start();
    push_burst(16'hC00, T_BASIC);
    send_line(16'hC00, 1'b0, 16, 4, 1'b1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_pro_de", pro_de, 1'b0);
    check("rst_mid_pro_data", pro_data, 16'h0);
    exp_q.delete();
    start_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    frame_start();
    push_burst(16'hD00, T_BASIC);
    send_line(16'hD00, 1'b0, 16, 14, 1'b1);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
